mem_buffer_loader: RTL and testbench
====================================

# mem_buffer_loader

Fetch engine between the external memory port and the on-chip ifmap/weight buffers of the `amadeus` accelerator. Given a start byte address, a word count and a buffer base index, it issues sequential single-word memory reads, captures each returned word and writes it into the target buffer's write port, honouring buffer backpressure. The top level instantiates one per buffer; the memory arbiter muxes their `mem_read`/`mem_addr`.

## Interface
Parameters:
- `ADDR_W`, `` `MEM_ADDR_SIZE ``: memory byte-address width.
- `DATA_W`, `` `MEM_BANDWIDTH*8 ``: memory word width.
- `LEN_W`, 16: word-count width.
- `BUF_AW`, 10: buffer index width.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: launches a transfer; sampled only in IDLE.
- `start_addr` in ADDR_W: first memory byte address; sampled with `start`.
- `num_words` in LEN_W: number of words to move; sampled with `start`.
- `buf_base` in BUF_AW: first buffer index; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `mem_addr` out ADDR_W: read address.
- `mem_read` out 1: read request.
- `mem_read_data` in DATA_W: read data.
- `mem_valid` in 1: read data valid.
- `buf_wr_en` out 1: buffer write valid.
- `buf_wr_addr` out BUF_AW: buffer index.
- `buf_wr_data` out DATA_W: buffer write data.
- `buf_ready` in 1: buffer accepts write.

## Operation
- FSM states: IDLE, REQ, WR, DONE.
- IDLE + `start`: latch `start_addr`, `num_words`, `buf_base`; clear the word counter. Go to REQ, or to DONE directly if `num_words == 0` (no memory access).
- REQ: drive `mem_read=1`, `mem_addr` = current address, held stable until `mem_valid`. On `mem_valid`, capture `mem_read_data` into the hold register and go to WR. `mem_read` drops the next cycle.
- WR: drive `buf_wr_en=1` with `buf_wr_addr`/`buf_wr_data`, all held stable until `buf_ready`. On the handshake:
  - counter += 1; mem address += `` `MEM_BANDWIDTH ``; buffer index += 1.
  - Go to DONE if counter == latched `num_words`, else REQ.
- DONE: `done=1` for one cycle, then IDLE.
- Only one read outstanding. `mem_valid` outside REQ is ignored.
- `start` while not in IDLE is ignored and does not change latched values.
- Arithmetic wrap-around:
  - memory address wraps modulo 2^ADDR_W;
  - buffer index wraps modulo 2^BUF_AW (e.g. base 1022, 4 words → 1022, 1023, 0, 1).

## Timing
- Reset (async assert, sync release): state IDLE; `busy`, `done`, `mem_read`, `buf_wr_en` = 0; `mem_addr`, `buf_wr_addr`, `buf_wr_data` = 0.
- Reset mid-transfer aborts immediately: no `done`, no further requests, latched values discarded.
- Best case is 2 cycles/word (`mem_valid` in the first REQ cycle, `buf_ready` high).
  - `start` in cycle 0 → REQ in cycle 1; word k written in cycle 2k+2; `done` in cycle 2N+1.
- Memory stall: each cycle `mem_valid` is late adds one REQ cycle.
- Buffer stall: each cycle `buf_ready` is low adds one WR cycle.
- `num_words=0`: `done` in cycle 1; `busy` high only in cycle 1.

## Structure
- `amadeus_pkg` holds:
  - the `loader_state_e` enum (IDLE/REQ/WR/DONE);
  - `MEM_WORD_BYTES = `MEM_BANDWIDTH`;
  - the shared length width.
- Single flat module, no sub-module; the counter/address registers are too small to split out.

## Test plan
- N=4, `start_addr`=0x100, `buf_base`=0, immediate `mem_valid`, `buf_ready`=1 → reads at 0x100, 0x100+B, 0x100+2B, 0x100+3B (B = `` `MEM_BANDWIDTH ``); buffer writes to indices 0..3 with matching data; `done` in cycle 9.
- `mem_valid` delayed 3 cycles on word 1 → `mem_addr`/`mem_read` stable throughout; total latency +3.
- `buf_ready` low 2 cycles during word 2 → `buf_wr_*` held; no new `mem_read` issued; latency +2.
- `num_words`=0 → `done` in cycle 1; `mem_read` never asserted.
- `buf_base`=1022, N=3, plus `start` pulsed mid-transfer → writes 1022, 1023, 0; the second `start` has no effect.
- `rst_n` low during WR of word 1 → all outputs 0 immediately; no `done`; a fresh `start` after release runs normally.

Source files
------------

// File: rtl/amadeus_pkg.sv
// -----------------------------------------------------------------------------
// amadeus_pkg
// Shared types and constants for the amadeus accelerator datapath blocks.
//   - loader_state_e : state encoding of the memory-to-buffer fetch engine
//   - MEM_WORD_BYTES : bytes moved per memory word (address stride)
//   - LOADER_LEN_W   : width of transfer word counts
// The two memory-geometry macros fall back to a 32-bit byte address and a
// 4-byte memory word when the build does not provide them.
// -----------------------------------------------------------------------------
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

package amadeus_pkg;

    localparam int MEM_WORD_BYTES = `MEM_BANDWIDTH;
    localparam int LOADER_LEN_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } loader_state_e;

endpackage

// File: rtl/mem_buffer_loader.sv
// -----------------------------------------------------------------------------
// mem_buffer_loader
// Moves num_words consecutive memory words, starting at byte address
// start_addr, into an on-chip buffer starting at index buf_base. One read is
// outstanding at a time; each returned word is held until the buffer accepts
// it.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : launch a transfer (honoured only while idle)
//   start_addr          : first memory byte address   (sampled with start)
//   num_words           : words to move, 0 allowed    (sampled with start)
//   buf_base            : first buffer index          (sampled with start)
//   busy                : transfer in progress, including the done cycle
//   done                : one-cycle completion pulse
//   mem_addr/mem_read   : read request, held until mem_valid
//   mem_read_data       : read data, qualified by mem_valid
//   mem_valid           : read data valid (ignored unless requesting)
//   buf_wr_en/_addr/_data : buffer write, held until buf_ready
//   buf_ready           : buffer accepts the write this cycle
// -----------------------------------------------------------------------------
module mem_buffer_loader
    import amadeus_pkg::*;
#(
    parameter int ADDR_W = `MEM_ADDR_SIZE,
    parameter int DATA_W = `MEM_BANDWIDTH * 8,
    parameter int LEN_W  = LOADER_LEN_W,
    parameter int BUF_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic [BUF_AW-1:0] buf_base,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_valid,
    output logic              buf_wr_en,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    input  logic              buf_ready
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;   // current memory byte address
    logic [BUF_AW-1:0] idx_q,   idx_d;    // current buffer index
    logic [DATA_W-1:0] hold_q,  hold_d;   // word waiting to be written
    logic [LEN_W-1:0]  num_q,   num_d;    // latched transfer length
    logic [LEN_W-1:0]  cnt_q,   cnt_d;    // words written so far
    logic [LEN_W-1:0]  cnt_inc;

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        num_d   = num_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    idx_d   = buf_base;
                    num_d   = num_words;
                    cnt_d   = '0;
                    // A zero-length request completes without touching memory.
                    state_d = (num_words == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_valid) begin
                    hold_d  = mem_read_data;
                    state_d = WR;
                end
            end
            WR: begin
                if (buf_ready) begin
                    cnt_d   = cnt_inc;
                    // Both pointers wrap naturally at their register widths.
                    addr_d  = addr_q + ADDR_W'(MEM_WORD_BYTES);
                    idx_d   = idx_q + BUF_AW'(1);
                    state_d = (cnt_inc == num_q) ? DONE : REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are pure decodes of registered state, so request and write
    // qualifiers stay glitch-free and stable for the whole handshake.
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign mem_read    = (state_q == REQ);
    assign buf_wr_en   = (state_q == WR);
    assign mem_addr    = addr_q;
    assign buf_wr_addr = idx_q;
    assign buf_wr_data = hold_q;

endmodule

// File: tb/tb_mem_buffer_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_buffer_loader
// Scoreboard bench for mem_buffer_loader. The stimulus process plans each
// transfer (addresses, per-word memory delays and buffer stalls), pushes the
// expected reads, writes and done cycle into queues, and the monitor pops and
// compares them whenever the DUT presents a handshake. Memory and buffer
// responders play the planned delays and inject noise outside handshakes.
// -----------------------------------------------------------------------------
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

module tb_mem_buffer_loader;

    localparam int ADDR_W = `MEM_ADDR_SIZE;
    localparam int DATA_W = `MEM_BANDWIDTH * 8;
    localparam int LEN_W  = 16;
    localparam int BUF_AW = 10;
    localparam int B      = `MEM_BANDWIDTH;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  num_words;
    logic [BUF_AW-1:0] buf_base;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_valid;
    logic              buf_wr_en;
    logic [BUF_AW-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              buf_ready;

    mem_buffer_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W),
        .BUF_AW(BUF_AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_addr   (start_addr),
        .num_words    (num_words),
        .buf_base     (buf_base),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_read_data(mem_read_data),
        .mem_valid    (mem_valid),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_data  (buf_wr_data),
        .buf_ready    (buf_ready)
    );

    typedef struct {
        logic [BUF_AW-1:0] idx;
        logic [DATA_W-1:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [ADDR_W-1:0] exp_rd_q[$];
    wr_t               exp_wr_q[$];
    int                exp_done_q[$];
    int                mem_delay_q[$];
    int                buf_stall_q[$];
    int                busy_from = 1;
    int                busy_to   = 0;
    int                md[8];
    int                bs[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Contents of external memory: a fixed scramble of the byte address.
    function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
        logic [63:0] h;
        h = (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
        return DATA_W'(h >> 17);
    endfunction

    // Memory responder: answers each new request after its planned delay.
    initial begin : mem_resp
        bit in_req;
        int wait_left;
        in_req        = 1'b0;
        wait_left     = 0;
        mem_valid     = 1'b0;
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_req    = 1'b0;
                mem_valid = 1'b0;
            end else if (mem_read) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    wait_left = 0;
                    if (mem_delay_q.size() > 0) wait_left = mem_delay_q.pop_front();
                end
                if (wait_left == 0) begin
                    mem_valid     = 1'b1;
                    mem_read_data = mem_model(mem_addr);
                    in_req        = 1'b0;
                end else begin
                    mem_valid     = 1'b0;
                    mem_read_data = DATA_W'($urandom);
                    wait_left--;
                end
            end else begin
                mem_valid     = ($urandom_range(0, 3) == 0);
                mem_read_data = DATA_W'($urandom);
                in_req        = 1'b0;
            end
        end
    end

    // Buffer responder: holds buf_ready low for each write's planned stall.
    initial begin : buf_resp
        bit in_wr;
        int stall_left;
        in_wr      = 1'b0;
        stall_left = 0;
        buf_ready  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_wr     = 1'b0;
                buf_ready = 1'b0;
            end else if (buf_wr_en) begin
                if (!in_wr) begin
                    in_wr      = 1'b1;
                    stall_left = 0;
                    if (buf_stall_q.size() > 0) stall_left = buf_stall_q.pop_front();
                end
                if (stall_left == 0) begin
                    buf_ready = 1'b1;
                    in_wr     = 1'b0;
                end else begin
                    buf_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                buf_ready = ($urandom_range(0, 1) == 1);
                in_wr     = 1'b0;
            end
        end
    end

    // Monitor: compares every handshake and the done pulse to the scoreboard.
    initial begin : monitor
        logic              prev_rd, prev_rd_hs, prev_wr, prev_wr_hs;
        logic [ADDR_W-1:0] prev_addr;
        logic [BUF_AW-1:0] prev_idx;
        logic [DATA_W-1:0] prev_data;
        wr_t               w;
        int                dc;
        prev_rd    = 1'b0;
        prev_rd_hs = 1'b0;
        prev_wr    = 1'b0;
        prev_wr_hs = 1'b0;
        prev_addr  = '0;
        prev_idx   = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            check("busy", busy, (cyc >= busy_from && cyc <= busy_to));
            if (mem_read && buf_wr_en) fail_now("read_during_write");
            if (mem_read && prev_rd && !prev_rd_hs)
                check("mem_addr_hold", mem_addr, prev_addr);
            if (buf_wr_en && prev_wr && !prev_wr_hs) begin
                check("wr_addr_hold", buf_wr_addr, prev_idx);
                check("wr_data_hold", buf_wr_data, prev_data);
            end
            if (mem_read && mem_valid) begin
                if (exp_rd_q.size() == 0) fail_now("extra_read");
                else check("rd_addr", mem_addr, exp_rd_q.pop_front());
            end
            if (buf_wr_en && buf_ready) begin
                if (exp_wr_q.size() == 0) begin
                    fail_now("extra_write");
                end else begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", buf_wr_addr, w.idx);
                    check("wr_data", buf_wr_data, w.data);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    fail_now("extra_done");
                end else begin
                    dc = exp_done_q.pop_front();
                    check("done_cycle", cyc, dc);
                end
            end
            prev_rd    = mem_read;
            prev_rd_hs = mem_read & mem_valid;
            prev_wr    = buf_wr_en;
            prev_wr_hs = buf_wr_en & buf_ready;
            prev_addr  = mem_addr;
            prev_idx   = buf_wr_addr;
            prev_data  = buf_wr_data;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_done"},        done,        0);
        check({tag, "_mem_read"},    mem_read,    0);
        check({tag, "_mem_addr"},    mem_addr,    0);
        check({tag, "_buf_wr_en"},   buf_wr_en,   0);
        check({tag, "_buf_wr_addr"}, buf_wr_addr, 0);
        check({tag, "_buf_wr_data"}, buf_wr_data, 0);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 8; k++) begin
            md[k] = 0;
            bs[k] = 0;
        end
    endtask

    // One transfer: plan expectations from the address/index arithmetic and
    // the planned stalls, launch it, optionally pulse stray starts, and either
    // run to completion or abort with reset at cycle start+abort_rel.
    task automatic run_xfer(input logic [ADDR_W-1:0] a, input int n,
                            input logic [BUF_AW-1:0] b, input bit noise,
                            input int abort_rel);
        int                s;
        int                total;
        logic [ADDR_W-1:0] ra;
        wr_t               w;
        @(posedge clk);
        #1;
        s     = cyc;
        total = 1;
        for (int k = 0; k < n; k++) begin
            ra     = a + ADDR_W'(k * B);
            w.idx  = b + BUF_AW'(k);
            w.data = mem_model(ra);
            exp_rd_q.push_back(ra);
            exp_wr_q.push_back(w);
            mem_delay_q.push_back(md[k]);
            buf_stall_q.push_back(bs[k]);
            total += 2 + md[k] + bs[k];
        end
        exp_done_q.push_back(s + total);
        busy_from  = s + 1;
        busy_to    = s + total;
        start      = 1'b1;
        start_addr = a;
        num_words  = LEN_W'(n);
        buf_base   = b;
        forever begin
            @(posedge clk);
            #1;
            if (abort_rel >= 0 && cyc == s + abort_rel) begin
                exp_rd_q.delete();
                exp_wr_q.delete();
                exp_done_q.delete();
                mem_delay_q.delete();
                buf_stall_q.delete();
                busy_to = cyc - 1;
                start   = 1'b0;
                #1 rst_n = 1'b0;
                #1 check_outputs_zero("abort");
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            if (cyc > s + total) break;
            if (noise && $urandom_range(0, 2) == 0) begin
                start      = 1'b1;
                start_addr = ADDR_W'($urandom);
                num_words  = LEN_W'($urandom_range(1, 9));
                buf_base   = BUF_AW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", exp_done_q.size(), 0);
    endtask

    initial begin : stimulus
        logic [ADDR_W-1:0] ra;
        logic [BUF_AW-1:0] rb;
        int                rn;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        num_words  = '0;
        buf_base   = '0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Best case, four words: done 9 cycles after start.
        clear_plan();
        run_xfer(ADDR_W'(32'h100), 4, '0, 1'b0, -1);

        // Word 1 read answered 3 cycles late.
        clear_plan();
        md[1] = 3;
        run_xfer(ADDR_W'(32'h100), 4, BUF_AW'(16), 1'b0, -1);

        // Buffer refuses word 2 for 2 cycles.
        clear_plan();
        bs[2] = 2;
        run_xfer(ADDR_W'(32'h200), 4, BUF_AW'(40), 1'b0, -1);

        // Zero-length transfer.
        clear_plan();
        run_xfer(ADDR_W'(32'h300), 0, BUF_AW'(5), 1'b0, -1);

        // Buffer index wrap with stray starts during the transfer.
        clear_plan();
        run_xfer(ADDR_W'(32'h400), 3, BUF_AW'(1022), 1'b1, -1);

        // Memory address wrap.
        clear_plan();
        run_xfer({ADDR_W{1'b1}} - ADDR_W'(2 * B - 1), 4, BUF_AW'(7), 1'b0, -1);

        // Reset while word 1 waits on the buffer, then a clean transfer.
        clear_plan();
        bs[1] = 6;
        run_xfer(ADDR_W'(32'h500), 3, BUF_AW'(100), 1'b0, 5);
        clear_plan();
        run_xfer(ADDR_W'(32'h600), 2, BUF_AW'(200), 1'b0, -1);

        // Randomised transfers.
        for (int t = 0; t < 40; t++) begin
            rn = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) ra = {ADDR_W{1'b1}} - ADDR_W'($urandom_range(0, 12));
            else ra = ADDR_W'($urandom);
            rb = BUF_AW'($urandom);
            for (int k = 0; k < 8; k++) begin
                md[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                bs[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            end
            run_xfer(ra, rn, rb, ($urandom_range(0, 1) == 1), -1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("reads_drained",  exp_rd_q.size(),   0);
        check("writes_drained", exp_wr_q.size(),   0);
        check("dones_drained",  exp_done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
